// File: rtl/usart_pkg.sv
// Shared definitions for the buffered USART transmitter: FSM encodings, frame constants, FIFO default.
// Zero latency (types and constants only); no flow control.
// USART_TX_PARITY_EN adds the PARITY state and stretches the frame to 11 bits.
package usart_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 8;
    localparam int DATA_BITS          = 8;

`ifdef USART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;
`else
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } tx_state_t;
`endif

    // Byte being serialised plus its precomputed parity bit.
    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 par;
    } frame_t;

    // A programmed bit time of zero still has to last one cycle.
    function automatic logic [11:0] eff_cpb(input logic [11:0] cpb);
        return (cpb == 12'd0) ? 12'd1 : cpb;
    endfunction

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/usart_tx_fifo.sv
// Synchronous byte FIFO with an occupancy count driving full/empty.
// Pop data is combinational from the head entry; a push lands one cycle later.
// A push while full is ignored unless a pop happens in the same cycle.
module usart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     serial_clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == CW'(0));
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge serial_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge serial_clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/usart_tx_buffered.sv
// Buffered async serial transmitter: FIFO of bytes feeding an 8N1 (8E1 with USART_TX_PARITY_EN) framer.
// Latency: a byte written while idle drives the start bit two edges after the write strobe.
// Backpressure: full flags a full FIFO; writes while full are dropped and latch the sticky overflow.
module usart_tx_buffered
    import usart_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        serial_clock,
    input  logic        reset_n,
    input  logic [11:0] clocks_per_bit,
    input  logic [7:0]  data_in,
    input  logic        latch_in,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        overflow,
    output logic        tx_pin
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     state;
    tx_state_t     state_n;
    logic [11:0]   bit_cnt;
    logic [11:0]   bit_cnt_n;
    logic [11:0]   cpb_lat;
    logic [11:0]   cpb_lat_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    frame_t        frm;
    frame_t        frm_n;
    logic          tx_n;
    logic          bit_done;
    logic          load_frame;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dat;
    logic [CW-1:0] fifo_count;

    usart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .serial_clock (serial_clock),
        .reset_n      (reset_n),
        .push         (latch_in),
        .push_dat     (data_in),
        .pop          (fifo_pop),
        .pop_dat      (fifo_dat),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count)
    );

    assign full     = fifo_full;
    assign empty    = (fifo_count == CW'(0));
    assign busy     = (state != ST_IDLE);
    assign bit_done = (bit_cnt == cpb_lat - 12'd1);

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        bit_idx_n  = bit_idx;
        cpb_lat_n  = cpb_lat;
        frm_n      = frm;
        load_frame = 1'b0;
        fifo_pop   = 1'b0;
        tx_n       = 1'b1;

        if (state != ST_IDLE) begin
            bit_cnt_n = bit_done ? 12'd0 : bit_cnt + 12'd1;
        end

        case (state)
            ST_IDLE: begin
                load_frame = !fifo_empty;
            end
            ST_START: begin
                if (bit_done) begin
                    state_n   = ST_DATA;
                    bit_idx_n = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef USART_TX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        bit_idx_n  = bit_idx + 3'd1;
                        frm_n.data = frm.data >> 1;
                    end
                end
            end
`ifdef USART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_n = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when more bytes wait.
                    load_frame = !fifo_empty;
                    state_n    = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (load_frame) begin
            fifo_pop   = 1'b1;
            state_n    = ST_START;
            bit_cnt_n  = 12'd0;
            frm_n.data = fifo_dat;
            frm_n.par  = even_parity(fifo_dat);
            cpb_lat_n  = eff_cpb(clocks_per_bit);
        end

        // Line level follows the state being entered so tx_pin can be a plain flop.
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = frm_n.data[0];
`ifdef USART_TX_PARITY_EN
            ST_PARITY: tx_n = frm_n.par;
`endif
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge serial_clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            bit_cnt <= 12'd0;
            bit_idx <= 3'd0;
            cpb_lat <= 12'd1;
            frm     <= '0;
            tx_pin  <= 1'b1;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            bit_idx <= bit_idx_n;
            cpb_lat <= cpb_lat_n;
            frm     <= frm_n;
            tx_pin  <= tx_n;
        end
    end

    always_ff @(posedge serial_clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (latch_in && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_usart_tx_buffered.sv
// Scoreboarded bench for usart_tx_buffered: writes push expected frames, a line monitor decodes tx_pin.
module tb_usart_tx_buffered;

`ifdef USART_TX_PARITY_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif

    typedef struct {
        logic [7:0] b;
        int         cpb;
    } exp_t;

    logic        serial_clock = 1'b0;
    logic        reset_n;
    logic [11:0] clocks_per_bit;
    logic [7:0]  data_in;
    logic        latch_in;
    logic        full;
    logic        empty;
    logic        busy;
    logic        overflow;
    logic        tx_pin;

    exp_t exp_q[$];
    int   start_cyc[$];
    int   compared       = 0;
    int   mismatched     = 0;
    int   cyc            = 0;
    int   frames_started = 0;

    usart_tx_buffered #(.FIFO_DEPTH(8)) dut (
        .serial_clock   (serial_clock),
        .reset_n        (reset_n),
        .clocks_per_bit (clocks_per_bit),
        .data_in        (data_in),
        .latch_in       (latch_in),
        .full           (full),
        .empty          (empty),
        .busy           (busy),
        .overflow       (overflow),
        .tx_pin         (tx_pin)
    );

    always #5 serial_clock = ~serial_clock;
    always @(posedge serial_clock) cyc <= cyc + 1;

    function automatic int eff(input logic [11:0] c);
        return (c == 12'd0) ? 1 : int'(c);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge serial_clock);
            #1;
        end
    endtask

    // Called just after a rising edge; the byte is captured on the next one.
    task automatic put(input logic [7:0] b, input bit accept);
        data_in  = b;
        latch_in = 1'b1;
        if (accept) exp_q.push_back('{b, eff(clocks_per_bit)});
        tick(1);
        latch_in = 1'b0;
    endtask

    task automatic busy_len(output int n);
        bit ended = 1'b0;
        n = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge serial_clock);
            if (busy) n++;
            else begin
                ended = 1'b1;
                break;
            end
        end
        if (!ended) check("busy_len_timeout", 0, 1);
        tick(1);
    endtask

    task automatic wait_drain(input int limit);
        bit done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge serial_clock);
            if (!busy && empty) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 0, 1);
        tick(1);
    endtask

    // Line monitor: decodes every frame and checks each serial_clock cycle of it.
    initial begin
        exp_t       e;
        logic       lv [0:10];
        int         errs;
        int         n;
        bit         aborted;
        logic [7:0] obs;
        forever begin
            @(negedge serial_clock);
            if (reset_n === 1'b1 && tx_pin === 1'b0) begin
                frames_started++;
                start_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required none", cyc);
                    n = eff(clocks_per_bit);
                    repeat (FRAME_LEN * n - 1) @(negedge serial_clock);
                end else begin
                    e = exp_q.pop_front();
                    lv[0] = 1'b0;
                    for (int i = 0; i < 8; i++) lv[1 + i] = e.b[i];
`ifdef USART_TX_PARITY_EN
                    lv[9] = ^e.b;
`endif
                    lv[FRAME_LEN - 1] = 1'b1;
                    errs    = 0;
                    obs     = 8'h00;
                    aborted = 1'b0;
                    for (int b = 0; b < FRAME_LEN && !aborted; b++) begin
                        for (int c = 0; c < e.cpb; c++) begin
                            if (b != 0 || c != 0) @(negedge serial_clock);
                            if (reset_n !== 1'b1) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (tx_pin !== lv[b]) errs++;
                            if (c == 0 && b >= 1 && b <= 8) obs[b - 1] = tx_pin;
                        end
                    end
                    if (!aborted) begin
                        compared++;
                        if (errs != 0 || obs !== e.b) begin
                            mismatched++;
                            $display("FAIL frame: got byte %02h with %0d bad line cycles, required byte %02h",
                                     obs, errs, e.b);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int si;
        bit seen;

        reset_n        = 1'b0;
        latch_in       = 1'b0;
        data_in        = 8'h00;
        clocks_per_bit = 12'd4;
        repeat (2) @(negedge serial_clock);
        check("rst_tx", tx_pin, 1);
        check("rst_busy", busy, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        @(posedge serial_clock);
        #1 reset_n = 1'b1;
        tick(2);

        // Single 0x55 frame at 4 cycles per bit.
        put(8'h55, 1);
        @(negedge serial_clock);
        check("queued_empty", empty, 0);
        check("queued_busy", busy, 0);
        check("queued_tx", tx_pin, 1);
        @(posedge serial_clock);
        #1;
        check("start_tx", tx_pin, 0);
        check("start_busy", busy, 1);
        check("start_empty", empty, 1);
        busy_len(n);
        check("busy_cycles_cpb4", n, FRAME_LEN * 4);
        wait_drain(100);

        // Three back-to-back frames at 2 cycles per bit.
        clocks_per_bit = 12'd2;
        base = frames_started;
        si   = start_cyc.size();
        put(8'hA3, 1);
        put(8'h0F, 1);
        put(8'hFF, 1);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge serial_clock);
            #1;
            if (frames_started >= base + 3) begin
                seen = 1'b1;
                break;
            end
        end
        check("third_frame_seen", seen, 1);
        check("empty_after_third_pop", empty, 1);
        wait_drain(200);
        if (start_cyc.size() >= si + 3) begin
            check("gap_1_2", start_cyc[si + 1] - start_cyc[si], 2 * FRAME_LEN);
            check("gap_2_3", start_cyc[si + 2] - start_cyc[si + 1], 2 * FRAME_LEN);
        end else begin
            check("b2b_frame_count", start_cyc.size() - si, 3);
        end

        // Overflow: one byte in flight plus eight stored, then a dropped tenth.
        clocks_per_bit = 12'd4;
        base = frames_started;
        for (int i = 0; i < 9; i++) put(8'h10 + 8'(i), 1);
        check("ovf_full", full, 1);
        check("ovf_before", overflow, 0);
        put(8'hEE, 0);
        check("ovf_set", overflow, 1);
        check("ovf_full_after", full, 1);
        wait_drain(9 * FRAME_LEN * 4 + 100);
        check("ovf_frame_count", frames_started - base, 9);
        check("ovf_sticky", overflow, 1);

        // Reset during data bit 3 of 0x81 with another byte queued.
        put(8'h81, 1);
        put(8'h42, 1);
        tick(17);
        check("pre_reset_bit3", tx_pin, 0);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_tx", tx_pin, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_overflow", overflow, 0);
        data_in  = 8'h99;
        latch_in = 1'b1;
        tick(3);
        check("rst_write_ignored", empty, 1);
        latch_in = 1'b0;
        reset_n  = 1'b1;
        base = frames_started;
        tick(100);
        check("post_rst_frames", frames_started - base, 0);
        check("post_rst_tx", tx_pin, 1);

        // Write into a full FIFO on the very edge the framer pops.
        clocks_per_bit = 12'd2;
        base = frames_started;
        for (int i = 0; i < 9; i++) put(8'h30 + 8'(i), 1);
        check("pp_full", full, 1);
        tick(12);
        check("pp_full_before", full, 1);
        put(8'h5A, 1);
        check("pp_full_after", full, 1);
        check("pp_overflow", overflow, 0);
        wait_drain(10 * FRAME_LEN * 2 + 100);
        check("pp_frame_count", frames_started - base, 10);

        // clocks_per_bit of zero behaves as one.
        clocks_per_bit = 12'd0;
        put(8'h01, 1);
        tick(1);
        busy_len(n);
        check("busy_cycles_cpb0", n, FRAME_LEN);
        wait_drain(50);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/usart_tx_buffered.md
USART_TX_BUFFERED -- requirements
Module: usart_tx_buffered

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the byte buffer depth; it must be a power of two, 2..64.
REQ-002 SHALL have port serial_clock, input, 1 bit: the single clock, typically 3.6864MHz.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port clocks_per_bit, input, 12 bits: serial_clock cycles per serial bit.
REQ-005 SHALL have port data_in, input, 8 bits: byte to enqueue.
REQ-006 SHALL have port latch_in, input, 1 bit: single-cycle write strobe for data_in.
REQ-007 SHALL have port full, output, 1 bit: FIFO cannot accept a byte.
REQ-008 SHALL have port empty, output, 1 bit: FIFO holds no bytes.
REQ-009 SHALL have port busy, output, 1 bit: a frame is on the line.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag for a write dropped while full.
REQ-011 SHALL have port tx_pin, output, 1 bit: serial line, idle high.

Function
REQ-012 SHALL enqueue data_in on any serial_clock edge where latch_in=1 and full=0.
REQ-013 SHALL drop a write while full=1, leave FIFO contents unchanged and set overflow until reset.
REQ-014 SHALL provide FSM states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-015 SHALL, in IDLE with empty=0, pop one byte and enter START on the next edge; tx_pin goes low at that edge.
REQ-016 SHALL hold each bit for exactly max(clocks_per_bit,1) cycles, timed by a bit counter; clocks_per_bit=0 is treated as 1.
REQ-017 SHALL send frame order: start (0), data bits 0..7 (LSB first), [parity], stop (1).
REQ-018 SHALL, at the end of STOP, pop the next byte and go to START if the FIFO is not empty (back-to-back frames, no idle gap); otherwise go to IDLE.
REQ-019 SHALL, on a simultaneous write and pop, perform both; the count is unchanged and a write to a full FIFO coincident with a pop is accepted.
REQ-020 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; full and empty derive from an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-021 SHALL sample clocks_per_bit only at frame start; a mid-frame change affects the next frame only.
REQ-022 SHALL drive busy=1 in every state except IDLE; tx_pin SHALL be registered (glitch-free).

Reset
REQ-023 SHALL, while reset_n=0, force tx_pin=1, busy=0, empty=1, full=0, overflow=0, FSM=IDLE, pointers/count/bit counter=0.
REQ-024 SHALL, on reset mid-frame, abort the frame immediately (line high), discard FIFO contents, and accept no writes until reset_n=1.

Configuration
REQ-025 SHALL, with USART_TX_PARITY_EN defined, insert one even-parity bit (XOR of data bits) between bit 7 and stop: 11-bit frame.
REQ-026 SHALL, without USART_TX_PARITY_EN, omit the PARITY state entirely: 10-bit frame (8N1).

Structure
REQ-027 SHALL take FSM state encodings, frame-length constants and the default FIFO depth from shared package usart_pkg.
REQ-028 SHALL implement the buffer as sub-module usart_tx_fifo (sync FIFO: push, pop, data, full, empty, count); FSM and bit timing stay in the top module.

Verification
REQ-029 SHALL verify: clocks_per_bit=4, write 0x55 while idle -> tx_pin 0,1,0,1,0,1,0,1,0,1 each 4 cycles, busy high 40 cycles (44 with parity, parity bit 0).
REQ-030 SHALL verify: write 0xA3,0x0F,0xFF on consecutive cycles, clocks_per_bit=2 -> three contiguous frames, no high gap between stop and next start, empty=1 after third pop.
REQ-031 SHALL verify: FIFO_DEPTH=8, 9 writes during frame 1 (1 popped, 8 stored) then a 10th -> 10th dropped, overflow=1, exactly 9 frames emitted.
REQ-032 SHALL verify: reset_n low at data bit 3 of 0x81 -> tx_pin high within the same cycle, busy=0, empty=1, no further frames after release.
REQ-033 SHALL verify: clocks_per_bit=0, write 0x01 -> 1-cycle bits, frame 10 cycles.
REQ-034 SHALL verify: write while full coincident with FSM pop -> byte accepted, full stays 1, overflow stays 0.
